// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the fetch front end.
package core_pkg;
   typedef enum logic [1:0] {BOOT, REQ, WAIT} pc_gen_state_e;
   localparam logic [31:0] BOOT_ADDR_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/pc_gen_buf.sv
// pc_gen_buf: single-entry instruction buffer between fetch and decode.
module pc_gen_buf (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        flush_i,
   input  logic        load_i,
   input  logic [31:0] instr_i,
   input  logic [31:0] pc_i,
   input  logic        ready_i,
   output logic        valid_o,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o
);
   logic        valid_q, valid_d;
   logic [31:0] instr_q, instr_d, pc_q, pc_d;
   always_comb begin
      valid_d = flush_i ? 1'b0 : load_i ? 1'b1 : (ready_i ? 1'b0 : valid_q);
      instr_d = load_i ? instr_i : instr_q;
      pc_d    = load_i ? pc_i : pc_q;
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         instr_q <= '0;
         pc_q    <= '0;
      end else begin
         valid_q <= valid_d;
         instr_q <= instr_d;
         pc_q    <= pc_d;
      end
   end
   assign valid_o = valid_q;
   assign instr_o = instr_q;
   assign pc_o    = pc_q;
endmodule

// File: rtl/pc_gen.sv
// pc_gen: PC generation and single-outstanding instruction fetch with redirect.
// Define PC_GEN_MISALIGN_CHECK_EN to reject misaligned targets via misalign_o.
module pc_gen import core_pkg::*; #(
   parameter logic [31:0] BOOT_ADDR = BOOT_ADDR_DEFAULT
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        stall_i,
   input  logic        branch_valid_i,
   input  logic        branch_taken_i,
   input  logic [31:0] branch_target_i,
   input  logic        jump_valid_i,
   input  logic [31:0] jump_target_i,
   output logic        fetch_req_o,
   output logic [31:0] fetch_addr_o,
   input  logic        fetch_gnt_i,
   input  logic        fetch_rvalid_i,
   input  logic [31:0] fetch_rdata_i,
   output logic        instr_valid_o,
   output logic [31:0] instr_o,
   output logic [31:0] instr_pc_o,
   input  logic        instr_ready_i,
   output logic        flush_o
`ifdef PC_GEN_MISALIGN_CHECK_EN
   ,output logic       misalign_o
`endif
);
   pc_gen_state_e state_q, state_d;
   logic [31:0]   pc_q, pc_d, req_pc_q, req_pc_d, tgt_raw, target;
   logic          stale_q, stale_d, br_take, redirect, load;
   assign br_take = branch_valid_i & branch_taken_i;
   assign tgt_raw = br_take ? branch_target_i : jump_target_i;
`ifdef PC_GEN_MISALIGN_CHECK_EN
   logic mis, misalign_q;
   assign mis      = (br_take | jump_valid_i) & (|tgt_raw[1:0]);
   assign target   = tgt_raw;
   assign redirect = (br_take | jump_valid_i) & !mis;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) misalign_q <= 1'b0;
      else misalign_q <= mis;
   end
   assign misalign_o = misalign_q;
`else
   assign target   = {tgt_raw[31:2], 2'b00};
   assign redirect = br_take | jump_valid_i;
`endif
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      req_pc_d    = req_pc_q;
      stale_d     = stale_q;
      fetch_req_o = 1'b0;
      load        = 1'b0;
      case (state_q)
         BOOT: state_d = REQ;
         REQ: begin
            fetch_req_o = !stall_i && (!instr_valid_o || instr_ready_i);
            // a grant coinciding with a redirect leaves a response we must drop
            if (fetch_req_o && fetch_gnt_i) begin
               state_d  = WAIT;
               req_pc_d = pc_q;
               stale_d  = redirect;
            end
            if (redirect) pc_d = target;
         end
         WAIT: begin
            if (fetch_rvalid_i) begin
               state_d = REQ;
               stale_d = 1'b0;
               load    = !stale_q && !redirect;
               if (load) pc_d = req_pc_q + 32'd4;
            end else if (redirect) stale_d = 1'b1;
            if (redirect) pc_d = target;
         end
         default: state_d = BOOT;
      endcase
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= BOOT;
         pc_q     <= BOOT_ADDR;
         req_pc_q <= BOOT_ADDR;
         stale_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         req_pc_q <= req_pc_d;
         stale_q  <= stale_d;
      end
   end
   assign fetch_addr_o = pc_q;
   assign flush_o      = redirect;
   pc_gen_buf u_buf (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (redirect),
      .load_i  (load),
      .instr_i (fetch_rdata_i),
      .pc_i    (req_pc_q),
      .ready_i (instr_ready_i),
      .valid_o (instr_valid_o),
      .instr_o (instr_o),
      .pc_o    (instr_pc_o)
   );
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed checks of pc_gen fetch sequencing, redirects, buffer and reset.
module tb_pc_gen;
   logic        clk_i = 1'b0, rst_ni = 1'b0;
   logic        stall_i = 1'b0, branch_valid_i = 1'b0, branch_taken_i = 1'b0, jump_valid_i = 1'b0;
   logic [31:0] branch_target_i = '0, jump_target_i = '0;
   logic        fetch_req_o, fetch_gnt_i = 1'b1, fetch_rvalid_i = 1'b1;
   logic [31:0] fetch_addr_o, fetch_rdata_i, instr_o, instr_pc_o;
   logic        instr_valid_o, instr_ready_i = 1'b1, flush_o;
   logic [31:0] gaddr = '0;
   int          total = 0, bad = 0;
`ifdef PC_GEN_MISALIGN_CHECK_EN
   logic misalign_o;
`endif
   pc_gen dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .stall_i(stall_i),
      .branch_valid_i(branch_valid_i), .branch_taken_i(branch_taken_i),
      .branch_target_i(branch_target_i), .jump_valid_i(jump_valid_i),
      .jump_target_i(jump_target_i), .fetch_req_o(fetch_req_o),
      .fetch_addr_o(fetch_addr_o), .fetch_gnt_i(fetch_gnt_i),
      .fetch_rvalid_i(fetch_rvalid_i), .fetch_rdata_i(fetch_rdata_i),
      .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
      .instr_ready_i(instr_ready_i), .flush_o(flush_o)
`ifdef PC_GEN_MISALIGN_CHECK_EN
      ,.misalign_o(misalign_o)
`endif
   );
   always #5 clk_i = ~clk_i;
   // memory model: data is a function of the last granted address
   always @(posedge clk_i) if (fetch_req_o && fetch_gnt_i) gaddr <= fetch_addr_o;
   assign fetch_rdata_i = 32'hC0DE_0000 ^ gaddr;
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clk_i);
      @(negedge clk_i);
   endtask
   initial begin
      @(negedge clk_i);
      check("rst_req", fetch_req_o, 0);
      check("rst_valid", instr_valid_o, 0);
      check("rst_instr", instr_o, 0);
      check("rst_ipc", instr_pc_o, 0);
      rst_ni = 1'b1;
      check("boot_req", fetch_req_o, 0);
      step();
      check("req0", fetch_req_o, 1);
      check("addr0", fetch_addr_o, 32'h0);
      step();
      check("wait_req", fetch_req_o, 0);
      step();
      check("v0", instr_valid_o, 1);
      check("ipc0", instr_pc_o, 32'h0);
      check("instr0", instr_o, 32'hC0DE_0000);
      check("addr4", fetch_addr_o, 32'h4);
      step();
      step();
      check("ipc4", instr_pc_o, 32'h4);
      check("instr4", instr_o, 32'hC0DE_0004);
      check("addr8", fetch_addr_o, 32'h8);
      step();
      fetch_rvalid_i = 1'b0;
      branch_valid_i = 1'b1; branch_taken_i = 1'b1; branch_target_i = 32'h100;
      #1 check("flush_wait", flush_o, 1);
      step();
      branch_valid_i = 1'b0; branch_taken_i = 1'b0; fetch_rvalid_i = 1'b1;
      check("flush_clr", instr_valid_o, 0);
      step();
      check("stale_drop", instr_valid_o, 0);
      check("addr100", fetch_addr_o, 32'h100);
      check("req100", fetch_req_o, 1);
      step();
      step();
      check("ipc100", instr_pc_o, 32'h100);
      check("addr104", fetch_addr_o, 32'h104);
      fetch_gnt_i = 1'b0;
      branch_valid_i = 1'b1; branch_taken_i = 1'b1; branch_target_i = 32'h200;
      jump_valid_i = 1'b1; jump_target_i = 32'h300;
      #1 check("flush_both", flush_o, 1);
      step();
      branch_valid_i = 1'b0; branch_taken_i = 1'b0; jump_valid_i = 1'b0; fetch_gnt_i = 1'b1;
      check("addr200", fetch_addr_o, 32'h200);
      check("req200", fetch_req_o, 1);
      check("clr200", instr_valid_o, 0);
      step();
      step();
      check("ipc200", instr_pc_o, 32'h200);
      instr_ready_i = 1'b0;
      #1 check("full_noreq", fetch_req_o, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("hold_v", instr_valid_o, 1);
         check("hold_instr", instr_o, 32'hC0DE_0200);
         check("hold_ipc", instr_pc_o, 32'h200);
         check("hold_req", fetch_req_o, 0);
      end
      instr_ready_i = 1'b1;
      #1 check("ready_req", fetch_req_o, 1);
      step();
      check("consumed", instr_valid_o, 0);
      step();
      check("ipc204", instr_pc_o, 32'h204);
      check("addr208", fetch_addr_o, 32'h208);
      jump_valid_i = 1'b1; jump_target_i = 32'hFFFF_FFFC;
      step();
      jump_valid_i = 1'b0;
      check("gj_clr", instr_valid_o, 0);
      step();
      check("gj_drop", instr_valid_o, 0);
      check("addr_top", fetch_addr_o, 32'hFFFF_FFFC);
      step();
      step();
      check("ipc_top", instr_pc_o, 32'hFFFF_FFFC);
      check("addr_wrap", fetch_addr_o, 32'h0);
      stall_i = 1'b1;
      #1 check("stall", fetch_req_o, 0);
      stall_i = 1'b0;
      fetch_gnt_i = 1'b0;
`ifdef PC_GEN_MISALIGN_CHECK_EN
      branch_valid_i = 1'b1; branch_taken_i = 1'b1; branch_target_i = 32'h102;
      #1 check("mis_noflush", flush_o, 0);
      step();
      branch_valid_i = 1'b0; branch_taken_i = 1'b0;
      check("mis_pulse", misalign_o, 1);
      check("mis_addr", fetch_addr_o, 32'h0);
      step();
      check("mis_end", misalign_o, 0);
      check("mis_addr2", fetch_addr_o, 32'h0);
`else
      jump_valid_i = 1'b1; jump_target_i = 32'h303;
      #1 check("align_flush", flush_o, 1);
      step();
      jump_valid_i = 1'b0;
      check("align_addr", fetch_addr_o, 32'h300);
`endif
      fetch_gnt_i = 1'b1;
      step();
      fetch_rvalid_i = 1'b0;
      rst_ni = 1'b0;
      #1 check("arst_req", fetch_req_o, 0);
      check("arst_valid", instr_valid_o, 0);
      check("arst_instr", instr_o, 0);
      check("arst_ipc", instr_pc_o, 0);
      fetch_rvalid_i = 1'b1;
      step();
      rst_ni = 1'b1;
      check("rel_boot", fetch_req_o, 0);
      step();
      check("rel_addr", fetch_addr_o, 32'h0);
      check("rel_req", fetch_req_o, 1);
      check("rel_valid", instr_valid_o, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
